// File: rtl/carrd_wb_arbiter.sv
// Round-robin writeback arbiter: shares the register-file write port among the
// five vector units and drives it from a one-cycle registered write stage.
module carrd_wb_arbiter #(
    parameter int NREQ = 5,
    parameter int DW   = 512,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NREQ-1:0]   wb_valid,
    output logic [NREQ-1:0]   wb_ready,
    input  logic [NREQ*AW-1:0] wb_dest,
    input  logic [NREQ*2-1:0] wb_sel,
    input  logic [NREQ*DW-1:0] wb_data,
    input  logic              rf_stall,
    output logic              v_reg_wr_en,
    output logic              x_reg_wr_en,
    output logic [AW-1:0]     reg_wr_addr,
    output logic [127:0]      reg_wr_data,
    output logic [127:0]      reg_wr_data_2,
    output logic [127:0]      reg_wr_data_3,
    output logic [127:0]      reg_wr_data_4,
    output logic [2:0]        wb_gnt_id,
    output logic              sel_err,
    output logic              wb_idle
);

    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic          v_en_q, v_en_d;
    logic          x_en_q, x_en_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [2:0]    gnt_q, gnt_d;
    logic          sel_err_q, sel_err_d;

    logic          found;
    logic [2:0]    win;
    logic          accept;
    logic [1:0]    win_sel;

    // Rotating priority search: the first valid unit at or after rr_ptr wins.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && wb_valid[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    // Ready is gated by nrst so no handshake completes while reset is held.
    assign accept  = found && !rf_stall && nrst;
    assign win_sel = wb_sel[int'(win)*2 +: 2];

    always_comb begin
        wb_ready = '0;
        if (accept) wb_ready[win] = 1'b1;
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        v_en_d    = 1'b0;
        x_en_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        gnt_d     = gnt_q;
        sel_err_d = sel_err_q;
        if (accept) begin
            rr_ptr_d  = (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;
            v_en_d    = (win_sel == 2'd1);
            x_en_d    = (win_sel == 2'd2);
            addr_d    = wb_dest[int'(win)*AW +: AW];
            data_d    = wb_data[int'(win)*DW +: DW];
            gnt_d     = win;
            // Invalid selects are still consumed so the unit never deadlocks.
            sel_err_d = sel_err_q | (win_sel == 2'd0) | (win_sel == 2'd3);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr_q  <= '0;
            v_en_q    <= 1'b0;
            x_en_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            gnt_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            v_en_q    <= v_en_d;
            x_en_q    <= x_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            gnt_q     <= gnt_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign v_reg_wr_en   = v_en_q;
    assign x_reg_wr_en   = x_en_q;
    assign reg_wr_addr   = addr_q;
    assign reg_wr_data   = data_q[127:0];
    assign reg_wr_data_2 = data_q[255:128];
    assign reg_wr_data_3 = data_q[383:256];
    assign reg_wr_data_4 = data_q[511:384];
    assign wb_gnt_id     = gnt_q;
    assign sel_err       = sel_err_q;
    assign wb_idle       = (wb_valid == '0) && !v_en_q && !x_en_q;

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// Self-checking bench for carrd_wb_arbiter: table-driven arbitration vectors,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_carrd_wb_arbiter;

    localparam int NREQ = 5;
    localparam int DW   = 512;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              nrst;
    logic [NREQ-1:0]   wb_valid;
    logic [NREQ-1:0]   wb_ready;
    logic [NREQ*AW-1:0] wb_dest;
    logic [NREQ*2-1:0] wb_sel;
    logic [NREQ*DW-1:0] wb_data;
    logic              rf_stall;
    logic              v_reg_wr_en, x_reg_wr_en;
    logic [AW-1:0]     reg_wr_addr;
    logic [127:0]      reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4;
    logic [2:0]        wb_gnt_id;
    logic              sel_err, wb_idle;

    carrd_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .nrst(nrst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dest(wb_dest), .wb_sel(wb_sel), .wb_data(wb_data), .rf_stall(rf_stall),
        .v_reg_wr_en(v_reg_wr_en), .x_reg_wr_en(x_reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .reg_wr_data_2(reg_wr_data_2),
        .reg_wr_data_3(reg_wr_data_3), .reg_wr_data_4(reg_wr_data_4),
        .wb_gnt_id(wb_gnt_id), .sel_err(sel_err), .wb_idle(wb_idle)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Per-unit request payloads, packed onto the buses by drive().
    logic [AW-1:0] r_dest [NREQ];
    logic [1:0]    r_sel  [NREQ];
    logic [DW-1:0] r_data [NREQ];

    // Reference model state: what the write port should show, and the rotation start.
    int            m_ptr;
    bit            m_v, m_x, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_gnt;
    int            last_acc;
    logic [NREQ-1:0] last_ready;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic            stall;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            wb_dest[i*AW +: AW] = r_dest[i];
            wb_sel[i*2 +: 2]    = r_sel[i];
            wb_data[i*DW +: DW] = r_data[i];
        end
    endtask

    task automatic req(input int i, input logic [AW-1:0] d, input logic [1:0] s, input logic [DW-1:0] x);
        r_dest[i] = d;
        r_sel[i]  = s;
        r_data[i] = x;
        wb_valid[i] = 1'b1;
        drive();
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // First valid unit scanning forward from ptr modulo NREQ, or -1 when none.
    function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_v = 0; m_x = 0; m_err = 0;
        m_addr = '0; m_data = '0; m_gnt = 0;
    endtask

    // One clock: compare every output to the model mid-cycle, then advance the model.
    task automatic cycle();
        int w;
        logic [NREQ-1:0] er;
        @(negedge clk);
        w  = model_winner(wb_valid, m_ptr);
        er = '0;
        if (w >= 0 && !rf_stall) er[w] = 1'b1;
        last_ready = wb_ready;
        check("ready", wb_ready, er);
        check("v_en", v_reg_wr_en, m_v);
        check("x_en", x_reg_wr_en, m_x);
        check("addr", reg_wr_addr, m_addr);
        check("data", {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data}, m_data);
        check("gnt_id", wb_gnt_id, m_gnt);
        check("sel_err", sel_err, m_err);
        check("idle", wb_idle, (wb_valid == '0) && !m_v && !m_x);
        @(posedge clk);
        if (w >= 0 && !rf_stall) begin
            m_v    = (r_sel[w] == 2'd1);
            m_x    = (r_sel[w] == 2'd2);
            m_addr = r_dest[w];
            m_data = r_data[w];
            m_gnt  = w;
            if (r_sel[w] == 2'd0 || r_sel[w] == 2'd3) m_err = 1'b1;
            m_ptr  = (w + 1) % NREQ;
            last_acc = w;
        end else begin
            m_v = 0;
            m_x = 0;
            last_acc = -1;
        end
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        wb_valid = '1;
        rf_stall = 1'b0;
        drive();
        model_reset();
        #1;
        check("rst_ready", wb_ready, '0);
        check("rst_v_en", v_reg_wr_en, 1'b0);
        check("rst_x_en", x_reg_wr_en, 1'b0);
        check("rst_addr", reg_wr_addr, '0);
        check("rst_data", reg_wr_data, '0);
        check("rst_gnt", wb_gnt_id, '0);
        check("rst_sel_err", sel_err, 1'b0);
        @(negedge clk);
        wb_valid = '0;
        @(posedge clk);
        #1 nrst = 1'b1;
        #1 check("rst_idle", wb_idle, 1'b1);
    endtask

    initial begin
        vec_t vecs[11];
        logic [DW-1:0] pat;

        for (int i = 0; i < NREQ; i++) begin
            r_dest[i] = AW'(i); r_sel[i] = 2'd1; r_data[i] = DW'(i + 1);
        end
        wb_valid = '0; rf_stall = 1'b0; nrst = 1'b0; last_acc = -1;
        drive();

        // Rotation vectors starting from pointer 0; expected grants derived by hand.
        vecs[0]  = '{5'b00000, 1'b0, 5'b00000};
        vecs[1]  = '{5'b00001, 1'b0, 5'b00001};
        vecs[2]  = '{5'b00101, 1'b0, 5'b00100};
        vecs[3]  = '{5'b00101, 1'b1, 5'b00000};
        vecs[4]  = '{5'b00101, 1'b0, 5'b00001};
        vecs[5]  = '{5'b00100, 1'b0, 5'b00100};
        vecs[6]  = '{5'b11000, 1'b0, 5'b01000};
        vecs[7]  = '{5'b10000, 1'b0, 5'b10000};
        vecs[8]  = '{5'b00010, 1'b0, 5'b00010};
        vecs[9]  = '{5'b00011, 1'b0, 5'b00001};
        vecs[10] = '{5'b00010, 1'b0, 5'b00010};

        do_reset();
        for (int n = 0; n < 11; n++) begin
            wb_valid = vecs[n].valid;
            rf_stall = vecs[n].stall;
            cycle();
            check($sformatf("tbl_ready[%0d]", n), last_ready, vecs[n].exp_ready);
        end
        wb_valid = '0; rf_stall = 1'b0;

        // VALU alone: granted at once, write appears the next cycle.
        do_reset();
        pat = {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
        req(0, 5'd3, 2'd1, pat);
        cycle();
        wb_valid[0] = 1'b0;
        check("valu_acc", last_acc, 0);
        check("valu_v_en", v_reg_wr_en, 1'b1);
        check("valu_addr", reg_wr_addr, 5'd3);
        check("valu_s1", reg_wr_data, {32{4'h1}});
        check("valu_s2", reg_wr_data_2, {32{4'h2}});
        check("valu_s3", reg_wr_data_3, {32{4'h3}});
        check("valu_s4", reg_wr_data_4, {32{4'h4}});
        check("valu_gnt", wb_gnt_id, 3'd0);
        cycle();

        // All five valid from pointer 0: accepted in order 0..4 on consecutive cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) req(i, AW'(i + 10), 2'd1, rand_data());
        for (int n = 0; n < NREQ; n++) begin
            cycle();
            check("rr_order", last_acc, n);
            if (last_acc >= 0) wb_valid[last_acc] = 1'b0;
            check("rr_wr_en", v_reg_wr_en, 1'b1);
            check("rr_gnt", wb_gnt_id, n);
        end
        cycle();
        cycle();
        check("rr_idle", wb_idle, 1'b1);

        // VRED scalar write held off by three stall cycles.
        pat = rand_data();
        pat[31:0] = 32'hDEADBEEF;
        req(4, 5'd7, 2'd2, pat);
        rf_stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            check("stall_no_acc", last_acc, -1);
        end
        rf_stall = 1'b0;
        cycle();
        wb_valid[4] = 1'b0;
        check("stall_acc", last_acc, 4);
        check("stall_x_en", x_reg_wr_en, 1'b1);
        check("stall_v_en", v_reg_wr_en, 1'b0);
        check("stall_data", reg_wr_data[31:0], 32'hDEADBEEF);
        check("stall_addr", reg_wr_addr, 5'd7);

        // VSLDU with an invalid select: consumed, no enable, sticky error.
        req(3, 5'd9, 2'd0, rand_data());
        cycle();
        wb_valid[3] = 1'b0;
        check("bad_sel_acc", last_acc, 3);
        check("bad_sel_v", v_reg_wr_en, 1'b0);
        check("bad_sel_x", x_reg_wr_en, 1'b0);
        check("bad_sel_err", sel_err, 1'b1);
        req(1, 5'd2, 2'd1, rand_data());
        cycle();
        wb_valid[1] = 1'b0;
        check("err_sticky_v", v_reg_wr_en, 1'b1);
        check("err_sticky", sel_err, 1'b1);
        cycle();

        // Reset pulsed right after a VMUL accept drops the pending write.
        req(1, 5'd4, 2'd1, rand_data());
        cycle();
        wb_valid[1] = 1'b0;
        check("pre_rst_v", v_reg_wr_en, 1'b1);
        nrst = 1'b0;
        #1;
        check("async_v_en", v_reg_wr_en, 1'b0);
        check("async_err", sel_err, 1'b0);
        model_reset();
        #1 nrst = 1'b1;
        for (int i = 0; i < NREQ; i++) req(i, AW'(i), 2'd1, rand_data());
        cycle();
        check("post_rst_grant", last_acc, 0);

        // Randomized traffic obeying the hold-until-accepted rule.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!wb_valid[i] && ($urandom % 10) < 4)
                    req(i, AW'($urandom), (($urandom % 8) == 0) ? 2'(($urandom % 2) * 3) : 2'(1 + $urandom % 2), rand_data());
            rf_stall = (($urandom % 4) == 0);
            cycle();
            if (last_acc >= 0) wb_valid[last_acc] = 1'b0;
        end
        rf_stall = 1'b0;
        wb_valid = '0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carrd_wb_arbiter.md
Name: carrd_wb_arbiter

Overview:
- Shares the single vector/scalar register-file write port among the five vector functional units: VALU, VMUL, VLSU, VSLDU and VRED.
- Each unit presents a writeback request with a valid/ready handshake.
- The arbiter grants one request per cycle, round-robin, and drives a registered write port into the register file.
- It replaces per-opcode combinational write-port selection with explicit flow control and a one-cycle registered write stage.

Parameters:
- NREQ, 5, number of requesters (0=VALU, 1=VMUL, 2=VLSU, 3=VSLDU, 4=VRED).
- DW, 512, write data width (4 x 128-bit lane slices).
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- wb_valid  in  NREQ  per-unit request valid.
- wb_ready  out  NREQ  per-unit grant/accept, combinational.
- wb_dest  in  NREQ*AW  per-unit destination address; unit i uses bits [i*AW +: AW].
- wb_sel  in  NREQ*2  per-unit destination select: 1=vreg, 2=xreg, 0/3=invalid.
- wb_data  in  NREQ*DW  per-unit result; unit i uses bits [i*DW +: DW].
- rf_stall  in  1  write port unavailable this cycle (scalar core owns it).
- v_reg_wr_en  out  1  vector register write enable.
- x_reg_wr_en  out  1  scalar register write enable.
- reg_wr_addr  out  AW  write address.
- reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4  out  128 each  lane slices [127:0], [255:128], [383:256], [511:384].
- wb_gnt_id  out  3  index of the unit whose write is currently on the port.
- sel_err  out  1  sticky; set when an accepted request had wb_sel of 0 or 3.
- wb_idle  out  1  high when no wb_valid is set and no write is on the port.

Behaviour:
- Reset (nrst=0, async):
  - all write enables 0, reg_wr_addr 0, all data 0, wb_gnt_id 0, sel_err 0.
  - round-robin pointer rr_ptr = 0.
  - wb_ready = 0 while reset is asserted.
- Arbitration (combinational, each cycle):
  - Search wb_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - wb_ready[win] = 1 only if !rf_stall; all other ready bits are 0.
  - A request is accepted in a cycle where wb_valid[i] and wb_ready[i] are both 1.
- Requester rule: once wb_valid[i] is raised, it must stay high with dest/sel/data stable until accepted. The arbiter does not buffer unaccepted requests.
- Pointer update: on accept of unit i, rr_ptr <= (i==NREQ-1) ? 0 : i+1. With no accept, rr_ptr holds.
- Write stage (registered, latency 1): the cycle after an accept of unit i:
  - v_reg_wr_en = (sel==1) and x_reg_wr_en = (sel==2), pulsed for exactly one cycle.
  - reg_wr_addr = dest; the four data outputs carry data slices; wb_gnt_id = i.
  - For an xreg write, only reg_wr_data[31:0] is meaningful; all slices are still driven from data.
- No accept in a cycle: both enables go to 0 the next cycle. Address, data and wb_gnt_id hold their last values.
- Throughput: back-to-back accepts on consecutive cycles give consecutive writes; maximum one write per cycle.
- Invalid sel (0 or 3): the request is still accepted, so the unit is not deadlocked. No enable asserts, and sel_err is set until reset.
- rf_stall:
  - Suppresses all ready bits for that cycle.
  - Does not cancel a write already registered onto the port.
  - Does not move rr_ptr.
- Single requester: it is granted every non-stalled cycle, whatever rr_ptr is.
- Same-destination requests in one cycle: they are serviced in round-robin order. The later writer wins in the register file; no merging.
- Fairness: a continuously valid unit is accepted within NREQ non-stalled cycles.
- Reset mid-operation: a pending registered write is dropped (enables forced to 0) and rr_ptr returns to 0. Requesters must re-present after reset.
- wb_idle = (wb_valid==0) && !v_reg_wr_en && !x_reg_wr_en.

Test Plan:
- Reset release with no requests -> all enables 0, wb_ready=0, wb_idle=1, sel_err=0.
- Only VALU valid (dest=3, sel=1, data lanes 0x11..,0x22..,0x33..,0x44..) -> wb_ready[0]=1 the same cycle; next cycle v_reg_wr_en=1, reg_wr_addr=3, four slices match, wb_gnt_id=0.
- All five valid and held for 5 cycles, rr_ptr=0 -> accept order 0,1,2,3,4; writes on 5 consecutive cycles carrying wb_gnt_id 0..4; then wb_idle=1.
- VRED valid with sel=2, dest=7, data[31:0]=0xDEADBEEF, with rf_stall=1 for 3 cycles -> wb_ready stays 0 for 3 cycles; accepted on cycle 4; next cycle x_reg_wr_en=1, v_reg_wr_en=0, reg_wr_data[31:0]=0xDEADBEEF.
- VSLDU valid with sel=0 -> accepted; no enable asserts; sel_err=1 and stays 1 through later valid writes until nrst.
- nrst pulsed low for a partial cycle right after a VMUL accept -> enables 0 immediately (async); after release, the next grant with all units valid goes to VALU (rr_ptr=0).
